// File: rtl/switch_entry_if.sv
// Switch/value bundle for switch_entry: four raw push-buttons in,
// edited value, change strobe and debounced levels out.
interface switch_entry_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic [7:0] o_Value;
  logic       o_Changed;
  logic [3:0] o_Held;

  // Board/stimulus side: drives the buttons, observes the value.
  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_Value, o_Changed, o_Held
  );

  // Front-end side: conditions the buttons, owns the value.
  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_Value, o_Changed, o_Held
  );
endinterface

// File: rtl/switch_entry.sv
// switch_entry: debounced push-button front end editing an 8-bit value.
// Switch_1 increments, Switch_2 decrements, Switch_3 clears to INIT_VALUE,
// Switch_4 swaps nibbles. Each button goes through a 2-flop synchronizer
// and an independent debouncer; a rising debounced level is one event.
// Optional feature: define SWITCH_ENTRY_REPEAT_EN for auto-repeat of
// Switch_1/Switch_2 while held (REPEAT_DELAY, REPEAT_PERIOD).
module switch_entry #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_PERIOD  = 2500000,
  parameter logic [7:0]  INIT_VALUE     = 8'h00
) (
  input logic           i_Clk,
  input logic           i_Rst_L,
  switch_entry_if.slave sw
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  if (DEBOUNCE_LIMIT < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
    $error("switch_entry: DEBOUNCE_LIMIT must be >= 2 and repeat timings nonzero");
  end

  logic [3:0]            raw;
  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            held_q, held_d;
  logic [3:0]            held_r_q, held_r_d;
  logic [3:0]            press;
  logic [7:0]            value_q, value_d;
  logic                  changed_q, changed_d;
  logic                  rep_fire;
  logic                  inc_ev, dec_ev;

  assign raw   = {sw.i_Switch_4, sw.i_Switch_3, sw.i_Switch_2, sw.i_Switch_1};
  // A press is a debounced level that is high now but was low one cycle ago.
  assign press = held_q & ~held_r_q;

  // Synchronizer stages, debounce counters and the edge-detect copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sync1_d  = raw;
    sync2_d  = sync1_q;
    held_r_d = held_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        held_d[i] = ~held_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef SWITCH_ENTRY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  // rep_cnt_q == 0 means idle; otherwise it counts cycles since the press
  // (phase 0) or since the last repeat step (phase 1).
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic             one_held;

  // Shared hold counter: runs only while exactly one of Switch_1/Switch_2 is held.
  always_comb begin
    one_held    = held_q[0] ^ held_q[1];
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    if (!one_held) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (|press[1:0]) begin
      rep_cnt_d   = REP_W'(1);
      rep_phase_d = 1'b0;
    end else if (rep_cnt_q != '0) begin
      if (rep_cnt_q == (rep_phase_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY))) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = REP_W'(1);
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Value edit with priority clear > swap > inc/dec; inc and dec together cancel.
  always_comb begin
    inc_ev    = press[0] | (rep_fire & held_q[0]);
    dec_ev    = press[1] | (rep_fire & held_q[1]);
    value_d   = value_q;
    changed_d = 1'b0;
    if (press[2]) begin
      value_d   = INIT_VALUE;
      changed_d = 1'b1;
    end else if (press[3]) begin
      value_d   = {value_q[3:0], value_q[7:4]};
      changed_d = 1'b1;
    end else if (inc_ev ^ dec_ev) begin
      value_d   = inc_ev ? value_q + 8'd1 : value_q - 8'd1;
      changed_d = 1'b1;
    end
  end

  // State registers; every flop, including the debounce counters, clears on reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      held_q    <= '0;
      held_r_q  <= '0;
      value_q   <= INIT_VALUE;
      changed_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      held_r_q  <= held_r_d;
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign sw.o_Value   = value_q;
  assign sw.o_Changed = changed_q;
  assign sw.o_Held    = held_q;

endmodule

// File: tb/tb_switch_entry.sv
// Self-checking bench for switch_entry: directed cases from the button
// behaviour plus randomized button activity, checked every cycle against
// a behavioural model kept here.
module tb_switch_entry;

  localparam int         LIM  = 4;
  localparam logic [7:0] INIT = 8'h00;
`ifdef SWITCH_ENTRY_REPEAT_EN
  localparam int RDLY = 20;
  localparam int RPER = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_entry_if ifc ();

  switch_entry #(
    .DEBOUNCE_LIMIT(LIM),
`ifdef SWITCH_ENTRY_REPEAT_EN
    .REPEAT_DELAY(RDLY),
    .REPEAT_PERIOD(RPER),
`endif
    .INIT_VALUE(INIT)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .sw     (ifc)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_chg = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_sw(input logic [3:0] m);
    ifc.i_Switch_1 = m[0];
    ifc.i_Switch_2 = m[1];
    ifc.i_Switch_3 = m[2];
    ifc.i_Switch_4 = m[3];
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level flips once the last LIM synchronized samples all
  // disagree with it; an event is a debounced level that rose on the
  // previous edge and is acted on at this edge.
  logic [3:0] m_sync1 = '0, m_sync2 = '0, m_deb = '0, m_pend = '0;
  logic [7:0] m_value = INIT;
  logic       m_chg   = 1'b0;
  logic [3:0] win [$];
  logic [3:0] m_raw, m_new;
  logic       m_inc, m_dec, m_diff;
`ifdef SWITCH_ENTRY_REPEAT_EN
  bit  rep_run   = 1'b0;
  int  rep_start = 0;
  int  n_edge    = 0;
  int  rep_el;
  logic rep_one, rep_fire;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 = '0; m_sync2 = '0; m_deb = '0; m_pend = '0;
      m_value = INIT; m_chg = 1'b0;
      win.delete();
`ifdef SWITCH_ENTRY_REPEAT_EN
      rep_run = 1'b0;
`endif
    end else begin
      m_raw = {ifc.i_Switch_4, ifc.i_Switch_3, ifc.i_Switch_2, ifc.i_Switch_1};
      m_inc = m_pend[0];
      m_dec = m_pend[1];
`ifdef SWITCH_ENTRY_REPEAT_EN
      n_edge++;
      rep_one  = m_deb[0] ^ m_deb[1];
      rep_fire = 1'b0;
      if (rep_one && rep_run && !(m_pend[0] || m_pend[1])) begin
        rep_el = n_edge - rep_start;
        if (rep_el >= RDLY && ((rep_el - RDLY) % RPER) == 0) rep_fire = 1'b1;
      end
      if (!rep_one) rep_run = 1'b0;
      else if (m_pend[0] || m_pend[1]) begin
        rep_run   = 1'b1;
        rep_start = n_edge;
      end
      m_inc = m_inc | (rep_fire & m_deb[0]);
      m_dec = m_dec | (rep_fire & m_deb[1]);
`endif
      m_chg = 1'b0;
      if (m_pend[2]) begin
        m_value = INIT; m_chg = 1'b1;
      end else if (m_pend[3]) begin
        m_value = {m_value[3:0], m_value[7:4]}; m_chg = 1'b1;
      end else if (m_inc && !m_dec) begin
        m_value = m_value + 8'd1; m_chg = 1'b1;
      end else if (m_dec && !m_inc) begin
        m_value = m_value - 8'd1; m_chg = 1'b1;
      end
      win.push_back(m_sync2);
      if (win.size() > LIM) void'(win.pop_front());
      m_new = m_deb;
      if (win.size() == LIM) begin
        for (int i = 0; i < 4; i++) begin
          m_diff = 1'b1;
          foreach (win[k]) if (win[k][i] == m_deb[i]) m_diff = 1'b0;
          if (m_diff) m_new[i] = ~m_deb[i];
        end
      end
      m_pend  = m_new & ~m_deb;
      m_deb   = m_new;
      m_sync2 = m_sync1;
      m_sync1 = m_raw;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("value",   ifc.o_Value,   m_value);
      check("changed", ifc.o_Changed, m_chg);
      check("held",    ifc.o_Held,    m_deb);
    end
    if (ifc.o_Changed === 1'b1) n_chg++;
  end

  // Press: hold long enough to debounce, release long enough to settle.
  task automatic press(input logic [3:0] m);
    @(negedge clk); set_sw(m);
    repeat (LIM + 4) @(negedge clk);
    set_sw(4'b0000);
    repeat (LIM + 6) @(negedge clk);
  endtask

  int c0;
  logic [3:0] rm;

  initial begin
    set_sw(4'b0000);
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    check("reset_value",   ifc.o_Value,   8'h00);
    check("reset_changed", ifc.o_Changed, 1'b0);
    check("reset_held",    ifc.o_Held,    4'b0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Press latency: o_Held at E5, value/changed at E6 only.
    set_sw(4'b0001);
    repeat (5) @(posedge clk);
    #1 check("held_before_E5", ifc.o_Held, 4'b0000);
    @(posedge clk); #1;
    check("held_at_E5",    ifc.o_Held,    4'b0001);
    check("value_at_E5",   ifc.o_Value,   8'h00);
    check("changed_at_E5", ifc.o_Changed, 1'b0);
    @(posedge clk); #1;
    check("value_at_E6",   ifc.o_Value,   8'h01);
    check("changed_at_E6", ifc.o_Changed, 1'b1);
    @(posedge clk); #1;
    check("changed_at_E7", ifc.o_Changed, 1'b0);
    @(negedge clk); set_sw(4'b0000);
    repeat (LIM + 6) @(negedge clk);

    // Short glitch: three raw cycles is not enough.
    c0 = n_chg;
    set_sw(4'b0001);
    repeat (3) @(negedge clk);
    set_sw(4'b0000);
    repeat (10) @(negedge clk);
    check("glitch_held",  ifc.o_Held,  4'b0000);
    check("glitch_value", ifc.o_Value, 8'h01);
    check("glitch_nochg", n_chg - c0,  0);

    // Wrap in both directions.
    press(4'b0010);
    check("dec_to_00", ifc.o_Value, 8'h00);
    press(4'b0010);
    check("wrap_down", ifc.o_Value, 8'hFF);
    press(4'b0001);
    check("wrap_up",   ifc.o_Value, 8'h00);

    // Inc and dec together cancel.
    c0 = n_chg;
    press(4'b0011);
    check("incdec_value", ifc.o_Value, 8'h00);
    check("incdec_nochg", n_chg - c0,  0);

    // Build 8'h5A, then swap and clear cases.
    repeat (8'h5A) press(4'b0001);
    check("built_5A", ifc.o_Value, 8'h5A);
    press(4'b1000);
    check("swap_5A",  ifc.o_Value, 8'hA5);
    press(4'b1000);
    check("swap_back", ifc.o_Value, 8'h5A);
    press(4'b1100);
    check("clear_beats_swap", ifc.o_Value, 8'h00);
    c0 = n_chg;
    press(4'b0100);
    check("clear_at_init_value", ifc.o_Value, 8'h00);
    check("clear_at_init_pulse", n_chg - c0,  1);

    // Reset while Switch_1 is held, then one fresh press after release.
    @(negedge clk); set_sw(4'b0001);
    repeat (10) @(negedge clk);
    check("held_press_value", ifc.o_Value, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_value",   ifc.o_Value,   8'h00);
    check("midrst_changed", ifc.o_Changed, 1'b0);
    check("midrst_held",    ifc.o_Held,    4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = n_chg;
    repeat (12) @(negedge clk);
    check("postrst_value", ifc.o_Value, 8'h01);
    check("postrst_pulse", n_chg - c0,  1);
    check("postrst_held",  ifc.o_Held,  4'b0001);
    set_sw(4'b0000);
    repeat (LIM + 6) @(negedge clk);

`ifdef SWITCH_ENTRY_REPEAT_EN
    // Long hold of Switch_1 so auto-repeat steps appear.
    @(negedge clk); set_sw(4'b0001);
    repeat (50) @(negedge clk);
    set_sw(4'b0000);
    repeat (20) @(negedge clk);
`endif

    // Randomized button activity with occasional asynchronous resets.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) rm[b] = ($urandom_range(0, 9) < 3);
      set_sw(rm);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk); set_sw(4'b0000);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
